systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_pkg.sv | 17 +
 rtl/systolic_feeder_if.sv | 28 ++
 rtl/systolic_feeder_skew_line.sv | 30 +++
 rtl/systolic_feeder.sv | 117 +++++++++++
 tb/tb_systolic_feeder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared constants and the feeder state type for the systolic array slice.
package systolic_pkg;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int K     = 4;
    localparam int ACC_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand handshake and PE-array edge bus between an operand source and the feeder.
interface systolic_feeder_if #(
    parameter int N = systolic_pkg::N,
    parameter int W = systolic_pkg::W
);

    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_a;
    logic [N*W-1:0] in_b;
    logic [N*W-1:0] out_a;
    logic [N*W-1:0] out_b;
    logic           pe_clear;
    logic           busy;
    logic           done;

    modport master (
        output start, in_valid, in_a, in_b,
        input  in_ready, out_a, out_b, pe_clear, busy, done
    );

    modport slave (
        input  start, in_valid, in_a, in_b,
        output in_ready, out_a, out_b, pe_clear, busy, done
    );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// Single-lane W-bit delay chain; output equals input delayed by DEPTH cycles.
module skew_line #(
    parameter int W     = 4,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    // Shift every cycle regardless of feeder state so bubbles keep flowing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage[s] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int s = 1; s < DEPTH; s++) begin
                stage[s] <= stage[s-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skewing operand feeder for an N x N systolic PE array.
// Optional feature: define SYSTOLIC_FEEDER_ERR_EN to add a sticky err output
// that flags start requests made while a product is in flight.
module systolic_feeder #(
    parameter int N = systolic_pkg::N,
    parameter int W = systolic_pkg::W,
    parameter int K = systolic_pkg::K
) (
    input  logic             clk,
    input  logic             reset,
    systolic_feeder_if.slave bus
`ifdef SYSTOLIC_FEEDER_ERR_EN
    ,
    output logic             err
`endif
);

    import systolic_pkg::*;

    localparam int BEAT_W  = (K > 1) ? $clog2(K) : 1;
    localparam int DRAIN_W = $clog2(2 * N);

    feeder_state_t      state;
    feeder_state_t      state_nxt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept;
    logic               last_beat;
    logic               drain_last;
    logic [N*W-1:0]     inj_a;
    logic [N*W-1:0]     inj_b;
    logic [N*W-1:0]     skew_a;
    logic [N*W-1:0]     skew_b;

    assign accept     = bus.in_valid && (state == ST_STREAM);
    assign last_beat  = accept && (beat_cnt == BEAT_W'(K - 1));
    assign drain_last = (drain_cnt == DRAIN_W'(2 * N - 1));

    // Idle cycles inject zero bubbles because the PE array never stalls.
    assign inj_a = accept ? bus.in_a : '0;
    assign inj_b = accept ? bus.in_b : '0;

    // Next-state logic for the product sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.start) state_nxt = ST_CLEAR;
            ST_CLEAR:  state_nxt = ST_STREAM;
            ST_STREAM: if (last_beat) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (drain_last) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any product in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat counter only advances on accepted beats and wraps after K beats.
    always_ff @(posedge clk) begin
        if (reset || state == ST_CLEAR) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
        end
    end

    // Drain counter times the 2N zero cycles that flush the array.
    always_ff @(posedge clk) begin
        if (reset || state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
        end
    end

    // Lane i is delayed i+1 cycles on both edges of the array.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.W(W), .DEPTH(i + 1)) u_skew_a (
            .clk   (clk),
            .reset (reset),
            .d     (inj_a[i*W +: W]),
            .q     (skew_a[i*W +: W])
        );
        skew_line #(.W(W), .DEPTH(i + 1)) u_skew_b (
            .clk   (clk),
            .reset (reset),
            .d     (inj_b[i*W +: W]),
            .q     (skew_b[i*W +: W])
        );
    end

    assign bus.out_a    = reset ? '0 : skew_a;
    assign bus.out_b    = reset ? '0 : skew_b;
    assign bus.in_ready = !reset && (state == ST_STREAM);
    assign bus.pe_clear = !reset && (state == ST_CLEAR);
    assign bus.busy     = !reset && (state != ST_IDLE);
    assign bus.done     = !reset && (state == ST_DONE);

`ifdef SYSTOLIC_FEEDER_ERR_EN
    // Sticky flag for start requests that arrive while a product is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (bus.start && state != ST_IDLE) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder, including a small 4x4 PE array model.
module tb_systolic_feeder;

    import systolic_pkg::*;

    localparam int TN = 4;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   ticks        = 0;
    int   t0           = 0;

    always #5 clk = ~clk;

    systolic_feeder_if #(.N(TN), .W(TW)) bus ();

`ifdef SYSTOLIC_FEEDER_ERR_EN
    logic err;
`endif

    systolic_feeder #(.N(TN), .W(TW), .K(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SYSTOLIC_FEEDER_ERR_EN
        ,
        .err   (err)
`endif
    );

    logic signed [TW-1:0]    a_in [TN][TN];
    logic signed [TW-1:0]    b_in [TN][TN];
    logic signed [TW-1:0]    pe_a [TN][TN];
    logic signed [TW-1:0]    pe_b [TN][TN];
    logic signed [ACC_W-1:0] acc  [TN][TN];

    function automatic logic signed [ACC_W-1:0] mul(input logic signed [TW-1:0] x,
                                                    input logic signed [TW-1:0] y);
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] ye;
        xe = x;
        ye = y;
        return xe * ye;
    endfunction

    // PE operand routing: left/top edges from the feeder, interior from neighbours.
    always_comb begin
        a_in = '{default: '0};
        b_in = '{default: '0};
        for (int i = 0; i < TN; i++) begin
            a_in[i][0] = bus.out_a[i*TW +: TW];
            b_in[0][i] = bus.out_b[i*TW +: TW];
            for (int j = 1; j < TN; j++) begin
                a_in[i][j] = pe_a[i][j-1];
                b_in[j][i] = pe_b[j-1][i];
            end
        end
    end

    // Output-stationary PE array model.
    always_ff @(posedge clk) begin
        for (int i = 0; i < TN; i++) begin
            for (int j = 0; j < TN; j++) begin
                if (reset) begin
                    pe_a[i][j] <= '0;
                    pe_b[i][j] <= '0;
                    acc[i][j]  <= '0;
                end else begin
                    pe_a[i][j] <= a_in[i][j];
                    pe_b[i][j] <= b_in[i][j];
                    acc[i][j]  <= bus.pe_clear ? '0 : acc[i][j] + mul(a_in[i][j], b_in[i][j]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic v,
                                  input logic [TN*TW-1:0] a, input logic [TN*TW-1:0] b);
        bus.start    = s;
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic issue_start();
        apply_stimulus(1'b1, 1'b0, '0, '0);
        tick();
        t0 = ticks;
        apply_stimulus(1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_done(input string tag, input int expected_latency);
        int guard = 0;
        while (bus.done !== 1'b1 && guard < 60) begin
            tick();
            guard++;
        end
        check_output({tag, "_latency"}, ticks - t0 + 1, expected_latency);
        tick();
        check_output({tag, "_done_pulse"}, bus.done, 0);
        check_output({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int done_seen;
        logic [TN*TW-1:0] va;
        logic [TN*TW-1:0] vb;

        $display("[TB] start");
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_in_ready", bus.in_ready, 0);
        check_output("rst_pe_clear", bus.pe_clear, 0);
        check_output("rst_done", bus.done, 0);
        check_output("rst_out_a", bus.out_a, 0);
        check_output("rst_out_b", bus.out_b, 0);
        reset = 1'b0;
        tick();

        // Back-to-back beats with a lane-0 marker on beat 0.
        issue_start();
        check_output("a_clear", bus.pe_clear, 1);
        check_output("a_busy", bus.busy, 1);
        check_output("a_not_ready_clear", bus.in_ready, 0);
        tick();
        check_output("a_ready", bus.in_ready, 1);
        check_output("a_clear_once", bus.pe_clear, 0);
        apply_stimulus(1'b0, 1'b1, 16'h0003, 16'h0002);
        tick();
        check_output("a_out_a_beat0", bus.out_a, 16'h0003);
        check_output("a_out_b_beat0", bus.out_b, 16'h0002);
        apply_stimulus(1'b0, 1'b1, '0, '0);
        tick();
        check_output("a_out_a_beat1", bus.out_a, 16'h0000);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, '0, '0);
        check_output("a_drain_ready", bus.in_ready, 0);
        check_output("a_drain_busy", bus.busy, 1);
        wait_done("a", 14);

        // Negative operand on the deepest lane must arrive bit-exact after 4 cycles.
        issue_start();
        tick();
        apply_stimulus(1'b0, 1'b1, 16'hB000, 16'h4000);
        tick();
        apply_stimulus(1'b0, 1'b1, '0, '0);
        tick();
        tick();
        check_output("b_lane3_early_a", bus.out_a, 16'h0000);
        check_output("b_lane3_early_b", bus.out_b, 16'h0000);
        tick();
        apply_stimulus(1'b0, 1'b0, '0, '0);
        check_output("b_lane3_a", bus.out_a, 16'hB000);
        check_output("b_lane3_b", bus.out_b, 16'h4000);
        wait_done("b", 14);

        // Three bubble cycles inject zeros and push done out by three cycles.
        issue_start();
        tick();
        apply_stimulus(1'b0, 1'b1, 16'h0001, 16'h0001);
        tick();
        check_output("c_beat0", bus.out_a, 16'h0001);
        for (int n = 0; n < 3; n++) begin
            apply_stimulus(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
            tick();
            check_output("c_bubble_a", 32'(bus.out_a[3:0]), 0);
            check_output("c_bubble_b", 32'(bus.out_b[3:0]), 0);
            check_output("c_bubble_ready", bus.in_ready, 1);
        end
        for (int k = 1; k < 4; k++) begin
            va = 16'(k + 1);
            apply_stimulus(1'b0, 1'b1, va, va);
            tick();
            check_output("c_beat_lane0", 32'(bus.out_a[3:0]), k + 1);
        end
        apply_stimulus(1'b0, 1'b0, '0, '0);
        wait_done("c", 17);

        // start with in_valid in IDLE takes no beat; start in STREAM is ignored.
        apply_stimulus(1'b1, 1'b1, 16'h7777, 16'h7777);
        tick();
        t0 = ticks;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        check_output("d_no_idle_beat", bus.out_a, 0);
        tick();
        apply_stimulus(1'b0, 1'b1, '0, '0);
        tick();
        apply_stimulus(1'b1, 1'b0, '0, '0);
        tick();
        check_output("d_stream_kept", bus.in_ready, 1);
        check_output("d_no_reclear", bus.pe_clear, 0);
`ifdef SYSTOLIC_FEEDER_ERR_EN
        check_output("d_err_set", err, 1);
`endif
        apply_stimulus(1'b0, 1'b1, '0, '0);
        tick();
        tick();
        tick();
        apply_stimulus(1'b0, 1'b0, '0, '0);
        wait_done("d", 15);
`ifdef SYSTOLIC_FEEDER_ERR_EN
        check_output("d_err_sticky", err, 1);
`endif

        // Reset after two accepted beats aborts the product silently.
        issue_start();
        tick();
        apply_stimulus(1'b0, 1'b1, 16'h1234, 16'h4321);
        tick();
        tick();
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        tick();
        check_output("e_busy", bus.busy, 0);
        check_output("e_ready", bus.in_ready, 0);
        check_output("e_clear", bus.pe_clear, 0);
        check_output("e_done", bus.done, 0);
        check_output("e_out_a", bus.out_a, 0);
        check_output("e_out_b", bus.out_b, 0);
        reset = 1'b0;
        tick();
        check_output("e_idle_after", bus.busy, 0);
        check_output("e_out_a_after", bus.out_a, 0);
`ifdef SYSTOLIC_FEEDER_ERR_EN
        check_output("e_err_cleared", err, 0);
`endif
        done_seen = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.done === 1'b1) done_seen++;
        end
        check_output("e_no_done", done_seen, 0);

        // Full product through the PE model: 7*I times -7*I gives -49*I.
        issue_start();
        tick();
        for (int k = 0; k < 4; k++) begin
            va = 16'h0007 << (4 * k);
            vb = 16'h0009 << (4 * k);
            apply_stimulus(1'b0, 1'b1, va, vb);
            tick();
        end
        apply_stimulus(1'b0, 1'b0, '0, '0);
        wait_done("f", 14);
        for (int i = 0; i < TN; i++) begin
            for (int j = 0; j < TN; j++) begin
                check_output($sformatf("f_c_%0d_%0d", i, j), 32'(acc[i][j]),
                             (i == j) ? 32'hFFFF_FFCF : 32'h0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
